// File: rtl/mem_pkg.sv
// Shared constants for the SPI flash read path: bus widths, arbiter state
// encoding and the flash read opcode used by mem_read.
package mem_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  localparam logic [7:0] READ_OPCODE = 8'h03;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_BUSY    = 2'd1;
  localparam arb_state_t ARB_RELEASE = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between fetch/LSU ports, the arbiter and mem_read.
// slave = arbiter view, master = requesters plus read engine.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_start;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;

  logic              grant_d;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, mem_done, mem_data,
    output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_start, grant_d
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, mem_done, mem_data,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_start, grant_d
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way winner selector. Fixed data-over-instruction priority by default;
// round-robin on a last-winner pointer when MEM_ARB_RR_EN is defined.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_d,
`endif
  output logic pick_d
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    pick_d = d_req;
    // On contention hand the grant to whichever port lost last time.
    if (i_req && d_req) begin
      pick_d = ~last_d;
    end
  end
`else
  always_comb begin
    pick_d = 1'b0;
    if (d_req) begin
      pick_d = 1'b1;
    end else if (i_req) begin
      pick_d = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the mem_read engine between instruction and data ports.
// Optional round-robin arbitration via MEM_ARB_RR_EN.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              grant_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              i_ack_q, d_ack_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              pick_d;
  logic              win_req;
  logic              any_req;
  logic              done_ok;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;
`endif

  mem_arb_pick u_pick (
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
`ifdef MEM_ARB_RR_EN
    .last_d (last_d_q),
`endif
    .pick_d (pick_d)
  );

  assign any_req = bus.i_req || bus.d_req;
  assign win_req = grant_q ? bus.d_req : bus.i_req;
  // A dropped request wins over a same-cycle mem_done.
  assign done_ok = (state_q == ARB_BUSY) && win_req && bus.mem_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_BUSY;
      ARB_BUSY: if (!win_req || bus.mem_done) state_d = ARB_RELEASE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= 1'b0;
      mem_addr_q <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      i_ack_q <= done_ok && !grant_q;
      d_ack_q <= done_ok && grant_q;
      if ((state_q == ARB_IDLE) && any_req) begin
        grant_q    <= pick_d;
        mem_addr_q <= pick_d ? bus.d_addr : bus.i_addr;
      end
      if (done_ok && !grant_q) i_rdata_q <= bus.mem_data;
      if (done_ok && grant_q)  d_rdata_q <= bus.mem_data;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Only completed transactions move the pointer; aborts leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (done_ok) begin
      last_d_q <= grant_q;
    end
  end
`endif

  // Decoded from the state register so reset drops it without waiting for a clock.
  assign bus.mem_start = (state_q == ARB_BUSY);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.grant_d   = grant_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random requesters and a random-latency
// read engine, checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } ack_t;

  ack_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Engine controls
  int          fix_lat     = -1;
  logic        fix_data_en = 1'b0;
  logic [31:0] fix_data    = '0;
  logic        spur_en     = 1'b0;
  logic        spur_force  = 1'b0;
  int          eng_cnt     = 0;
  int          eng_lat     = 0;

  // Reference model state
  logic              txn_act, last_win, m_grant, win, wreq, ei, ed, exp_start;
  logic [ADDR_W-1:0] m_addr, prev_iaddr, prev_daddr;
  logic [DATA_W-1:0] m_irdata, m_drdata;
  logic              prev_ireq, prev_dreq;
  int                low_run;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    return r[ADDR_W-1:0] & 24'hFFFFFC;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Read engine: done after a random number of BUSY cycles, optional stray dones.
  initial begin
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_done = 1'b0;
      if (bus.mem_start) begin
        if (eng_cnt == 0) eng_lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 6));
        if (eng_cnt >= eng_lat) begin
          bus.mem_done = 1'b1;
          bus.mem_data = fix_data_en ? fix_data : $urandom;
          eng_cnt = 0;
        end else begin
          eng_cnt++;
        end
      end else begin
        eng_cnt = 0;
        if (spur_force || (spur_en && $urandom_range(0, 7) == 0)) begin
          bus.mem_done = 1'b1;
          bus.mem_data = $urandom;
        end
      end
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      txn_act   = 1'b0;
      low_run   = 2;
      last_win  = 1'b0;
      m_grant   = 1'b0;
      m_addr    = '0;
      m_irdata  = '0;
      m_drdata  = '0;
      prev_ireq = 1'b0;
      prev_dreq = 1'b0;
    end else begin
      ei = 1'b0;
      ed = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (exp_q[0].port) begin
          ed = 1'b1;
          m_drdata = exp_q[0].data;
        end else begin
          ei = 1'b1;
          m_irdata = exp_q[0].data;
        end
        void'(exp_q.pop_front());
      end
      chk1("i_ack", bus.i_ack, ei);
      chk1("d_ack", bus.d_ack, ed);
      chk("i_rdata", bus.i_rdata, m_irdata);
      chk("d_rdata", bus.d_rdata, m_drdata);

      if (!txn_act) begin
        // The engine is re-armed only after two quiet cycles.
        exp_start = (low_run >= 2) && (prev_ireq || prev_dreq);
        chk1("mem_start", bus.mem_start, exp_start);
        if (exp_start) begin
`ifdef MEM_ARB_RR_EN
          win = (prev_ireq && prev_dreq) ? !last_win : prev_dreq;
`else
          win = prev_dreq;
`endif
          txn_act = 1'b1;
          m_grant = win;
          m_addr  = win ? prev_daddr : prev_iaddr;
        end else begin
          low_run++;
        end
      end else begin
        chk1("mem_start_busy", bus.mem_start, 1'b1);
      end
      chk1("grant_d", bus.grant_d, m_grant);
      chk("mem_addr", {8'b0, bus.mem_addr}, {8'b0, m_addr});

      if (txn_act) begin
        wreq = m_grant ? bus.d_req : bus.i_req;
        if (!wreq || bus.mem_done) begin
          if (wreq) begin
            exp_q.push_back('{port: m_grant, data: bus.mem_data, due: cyc + 1});
            last_win = m_grant;
          end
          txn_act = 1'b0;
          low_run = 0;
        end
      end
      prev_ireq  = bus.i_req;
      prev_dreq  = bus.d_req;
      prev_iaddr = bus.i_addr;
      prev_daddr = bus.d_addr;
    end
  end

  task automatic wait_ack(input logic port, input string name);
    int n;
    n = 0;
    while (!(port ? bus.d_ack : bus.i_ack) && n < 200) begin
      tick(1);
      n++;
    end
    chk1(name, port ? bus.d_ack : bus.i_ack, 1'b1);
  endtask

  task automatic step_ports();
    if (bus.i_req) begin
      if (bus.i_ack) begin
        if ($urandom_range(0, 1) == 1) bus.i_addr = rnd_addr();
        else bus.i_req = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        bus.i_req = 1'b0;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      bus.i_req  = 1'b1;
      bus.i_addr = rnd_addr();
    end
    if (bus.d_req) begin
      if (bus.d_ack) begin
        if ($urandom_range(0, 1) == 1) bus.d_addr = rnd_addr();
        else bus.d_req = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        bus.d_req = 1'b0;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      bus.d_req  = 1'b1;
      bus.d_addr = rnd_addr();
    end
  endtask

  task automatic clear_reqs();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  logic [DATA_W-1:0] saved;
  logic              first_port, got_first, i_seen, d_seen;
  int                n_ack, n;

  initial begin
    clear_reqs();
    bus.i_addr = '0;
    bus.d_addr = '0;
    tick(2);
    chk1("rst_mem_start", bus.mem_start, 1'b0);
    chk1("rst_i_ack", bus.i_ack, 1'b0);
    chk1("rst_d_ack", bus.d_ack, 1'b0);
    chk1("rst_grant_d", bus.grant_d, 1'b0);
    chk("rst_mem_addr", {8'b0, bus.mem_addr}, 32'h0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    tick(2);

    // Single instruction fetch
    fix_lat = 3; fix_data_en = 1'b1; fix_data = 32'hDEADBEEF;
    bus.i_req = 1'b1; bus.i_addr = 24'h000100;
    tick(1);
    chk1("single_start", bus.mem_start, 1'b1);
    chk("single_addr", {8'b0, bus.mem_addr}, 32'h00000100);
    wait_ack(1'b0, "single_ack");
    chk("single_rdata", bus.i_rdata, 32'hDEADBEEF);
    chk1("single_gap0", bus.mem_start, 1'b0);
    bus.i_req = 1'b0;
    tick(1);
    chk1("single_ack_pulse", bus.i_ack, 1'b0);
    chk1("single_gap1", bus.mem_start, 1'b0);
    tick(2);

    // Prior data win so that round-robin favours the instruction port next
    fix_data_en = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 24'h000200;
    wait_ack(1'b1, "prior_d_ack");
    bus.d_req = 1'b0;
    tick(3);

    // Contention
    bus.i_req = 1'b1; bus.i_addr = 24'h000010;
    bus.d_req = 1'b1; bus.d_addr = 24'h000020;
    got_first = 1'b0; first_port = 1'b0; i_seen = 1'b0; d_seen = 1'b0; n = 0;
    while (!(i_seen && d_seen) && n < 200) begin
      tick(1);
      n++;
      if (bus.i_ack) begin
        i_seen = 1'b1; bus.i_req = 1'b0;
        if (!got_first) begin got_first = 1'b1; first_port = 1'b0; end
      end
      if (bus.d_ack) begin
        d_seen = 1'b1; bus.d_req = 1'b0;
        if (!got_first) begin got_first = 1'b1; first_port = 1'b1; end
      end
    end
    chk1("contend_both", i_seen && d_seen, 1'b1);
`ifdef MEM_ARB_RR_EN
    chk1("contend_first_d", first_port, 1'b0);
`else
    chk1("contend_first_d", first_port, 1'b1);
`endif
    tick(3);

    // Back-to-back data transactions
    fix_lat = 2;
    bus.d_req = 1'b1; bus.d_addr = 24'h000004;
    n_ack = 0; n = 0;
    while (bus.d_req && n < 200) begin
      tick(1);
      n++;
      if (bus.d_ack) begin
        n_ack++;
        if (n_ack < 3) bus.d_addr = 24'(4 + 4 * n_ack);
        else bus.d_req = 1'b0;
      end
    end
    chk("b2b_acks", n_ack, 3);
    tick(3);

    // Abort of a granted instruction fetch with a data request waiting
    fix_lat = 20;
    bus.i_req = 1'b1; bus.i_addr = 24'h000300;
    tick(1);
    chk1("abort_granted_i", bus.grant_d, 1'b0);
    bus.d_req = 1'b1; bus.d_addr = 24'h000400;
    saved = bus.i_rdata;
    tick(4);
    bus.i_req = 1'b0;
    fix_lat = 3;
    tick(1);
    chk1("abort_start_low", bus.mem_start, 1'b0);
    i_seen = 1'b0; n = 0;
    while (!bus.d_ack && n < 200) begin
      if (bus.i_ack) i_seen = 1'b1;
      tick(1);
      n++;
    end
    chk1("abort_d_served", bus.d_ack, 1'b1);
    chk1("abort_no_i_ack", i_seen, 1'b0);
    chk("abort_i_rdata", bus.i_rdata, saved);
    bus.d_req = 1'b0;
    tick(3);

    // Stray mem_done while idle
    spur_force = 1'b1;
    repeat (3) begin
      tick(1);
      chk1("spur_no_start", bus.mem_start, 1'b0);
      chk1("spur_no_ack", bus.i_ack || bus.d_ack, 1'b0);
    end
    spur_force = 1'b0;
    tick(2);

    // Random traffic
    fix_lat = -1; spur_en = 1'b1;
    repeat (2000) begin
      step_ports();
      tick(1);
    end

    // Asynchronous reset in the middle of a transaction
    n = 0;
    while (!bus.mem_start && n < 200) begin
      step_ports();
      tick(1);
      n++;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_reqs();
    #1;
    chk1("mid_rst_start", bus.mem_start, 1'b0);
    chk1("mid_rst_ack", bus.i_ack || bus.d_ack, 1'b0);
    chk1("mid_rst_grant", bus.grant_d, 1'b0);
    chk("mid_rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
    tick(2);
    rst = 1'b0;
    repeat (1000) begin
      step_ports();
      tick(1);
    end

    clear_reqs();
    spur_en = 1'b0;
    tick(40);
    chk("drain_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares the single SPI flash read engine (`mem_read`) between the CPU instruction-fetch port and the load port. It accepts level-held requests from both ports, picks one winner, drives the engine's address and `start_fetch` handshake, and returns the fetched word with a one-cycle acknowledge. It also enforces the engine's rule that `start_fetch` must drop between transactions. The block sits between the core's fetch/LSU logic and `mem_read`.

## Interface
- `ADDR_W`, 24: byte address width forwarded to the engine.
- `DATA_W`, 32: fetched word width.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  instruction port request; held high until `i_ack` or abort.
- `i_addr`  in  ADDR_W  instruction address; stable while `i_req` is high.
- `i_ack`  out  1  one-cycle pulse; `i_rdata` is valid in that cycle.
- `i_rdata`  out  DATA_W  word returned to the instruction port.
- `d_req`, `d_addr`, `d_ack`, `d_rdata`: data port, same widths and rules as the `i_` port.
- `mem_addr`  out  ADDR_W  registered address to `mem_read.target_address`.
- `mem_start`  out  1  to `mem_read.start_fetch`.
- `mem_done`  in  1  from `mem_read.fetch_done`.
- `mem_data`  in  DATA_W  from `mem_read.fetched_data`.
- `grant_d`  out  1  current/last grant owner (1 = data port), for debug.

## Operation
- States: IDLE, BUSY, RELEASE (2-bit encoding).
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise choose a winner (policy below).
  - Latch the winner's address into `mem_addr`, set `grant_d`, go to BUSY.
- **BUSY**
  - `mem_start` = 1.
  - If `mem_done` = 1: capture `mem_data` into the winner's rdata register, pulse the winner's ack, go to RELEASE.
  - If the winner's `req` drops before `mem_done` (abort): go to RELEASE with no ack and no rdata update.
  - An abort takes priority over `mem_done` in the same cycle.
- **RELEASE**
  - `mem_start` = 0.
  - Go to IDLE unconditionally. This guarantees `mem_read` returns to its start state.
- Ack is registered: it is high during the RELEASE cycle only.
- `i_rdata`/`d_rdata` hold their last value until the next successful transaction on that port.
- `mem_done` is ignored outside BUSY.
- `mem_addr` changes only on the IDLE→BUSY transition.
- Address changes by a requester while it is granted are ignored.
- A requester may keep `req` high after its ack to issue back-to-back requests. It must present the new address by the cycle after the ack.
- Default policy: data port has fixed priority over the instruction port.
- Reset values: state IDLE; `mem_start`, `i_ack`, `d_ack`, `grant_d` = 0; `mem_addr`, `i_rdata`, `d_rdata` = 0; round-robin pointer = 0.
- Reset asserted mid-transaction:
  - `mem_start` drops immediately (asynchronous).
  - No ack is issued.
  - The engine is left to self-idle via its `start_fetch` = 0 path.

## Timing
- Request seen in IDLE at edge N → `mem_start` = 1 and `mem_addr` valid from N+1.
- `mem_done` high in cycle M → ack high and rdata valid in cycle M+1 (RELEASE).
- IDLE in M+2; earliest next `mem_start` in M+3.
- `mem_start` is low for a minimum of 2 cycles between transactions.
- Arbitration overhead per transaction is 3 cycles beyond the engine latency.
- Simultaneous requests are resolved in a single IDLE cycle; no combinational path from `req` to `mem_start`.
- `i_ack` and `d_ack` are never high in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration using a one-bit last-winner pointer.
  - When both ports request in IDLE, the port that did not win last is granted.
  - The pointer updates only on a successful ack (not on abort).
- Not defined:
  - Fixed priority, data over instruction.
  - No pointer register is built.

## Structure
- Shared package `mem_pkg`:
  - arbiter state encoding (ARB_IDLE, ARB_BUSY, ARB_RELEASE);
  - `ADDR_W`/`DATA_W` defaults;
  - the read opcode constant 0x03 used by `mem_read`.
- One natural sub-module: `mem_arb_pick`, a 2-input winner selector (fixed or round-robin under the macro). Its inputs are `i_req`, `d_req` and the pointer; its output is `pick_d`.
- FSM, address latch and rdata registers stay in `mem_arbiter`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 before the next edge; state IDLE.
- Single instruction fetch: `i_req` = 1, `i_addr` = 0x000100; model returns `mem_done` with 0xDEADBEEF.
  - `mem_addr` = 0x000100 one cycle after the request.
  - `i_ack` pulses exactly one cycle with `i_rdata` = 0xDEADBEEF.
  - `mem_start` is low for ≥2 cycles afterwards.
- Contention: `i_req` and `d_req` rise in the same cycle, addresses 0x000010 / 0x000020.
  - Without the macro: data served first (`mem_addr` = 0x000020), then instruction.
  - With `MEM_ARB_RR_EN`, after a prior data win: instruction served first.
- Back-to-back: `d_req` held high through 3 transactions at 0x4, 0x8, 0xC → three `d_ack` pulses, each with the matching model data, and `mem_start` gaps of exactly 2 cycles.
- Abort: drop `i_req` 5 cycles into BUSY → no `i_ack`, `i_rdata` unchanged, `mem_start` = 0 next cycle; a pending `d_req` is served afterwards.
- Spurious `mem_done` pulsed while in IDLE → no ack and no state change.
